move_rx_deframer: RTL

Serial receive stage for the inter-board move link: oversamples the incoming line, deframes 8N1 (optionally 8E1) UART frames, and hands each received move byte to the game FSM with a one-cycle `ready` strobe. Sits between the `jb[0]` input pin and the move mux feeding `game_fsm`. It filters glitches with majority voting and rejects bad frames rather than passing corrupt moves.

---
 rtl/move_rx_deframer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/move_rx_deframer.sv
// Oversampling UART receive deframer for the move link: 2-flop sync, 3-sample majority vote,
// 8N1 frames by default; define MOVE_RX_PARITY_EN for 8E1 with even-parity checking.
module move_rx_deframer #(
  parameter int unsigned CLK_PER_SAMP = 423,
  parameter int unsigned SAMP_PER_BIT = 16,
  parameter int unsigned PKT_LEN      = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rx,
  output logic               ready,
  output logic [PKT_LEN-1:0] data_out,
  output logic               frame_err,
  output logic               busy
);

  localparam int unsigned H  = SAMP_PER_BIT / 2;
  localparam int unsigned DW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
  localparam int unsigned SW = $clog2(SAMP_PER_BIT);
  localparam int unsigned BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_PER_SAMP - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMP_PER_BIT - 1);
  localparam logic [SW-1:0] SAMP_HM1  = SW'(H - 1);
  localparam logic [SW-1:0] SAMP_H    = SW'(H);
  localparam logic [SW-1:0] SAMP_HP1  = SW'(H + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(PKT_LEN - 1);

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    START,
    DATA,
`ifdef MOVE_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t             state_q;
  logic [1:0]         sync_q;
  logic [DW-1:0]      div_q;
  logic [SW-1:0]      samp_q;
  logic [BW-1:0]      bit_q;
  logic               dec_q;
  logic               s0_q;
  logic               s1_q;
  logic [PKT_LEN-1:0] shift_q;
  logic [PKT_LEN-1:0] data_q;
  logic               ready_q;
  logic               ferr_q;

  logic rx_s;
  logic active;
  logic tick;
  logic wrap;
  logic decide;
  logic maj;
  logic par_ok;

  assign rx_s   = sync_q[1];
  assign active = (state_q != ARM) && (state_q != IDLE);
  assign tick   = active && (div_q == DIV_LAST);
  assign wrap   = tick && (samp_q == SAMP_LAST);
  assign decide = tick && (samp_q == SAMP_HP1);
  assign maj    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

`ifdef MOVE_RX_PARITY_EN
  logic par_q;
  assign par_ok = ~^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  assign ready     = ready_q;
  assign frame_err = ferr_q;
  assign data_out  = data_q;
  assign busy      = active;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      div_q   <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      dec_q   <= 1'b0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef MOVE_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], rx};
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;

      if (tick) begin
        div_q  <= '0;
        samp_q <= wrap ? '0 : samp_q + 1'b1;
        if (samp_q == SAMP_HM1) s0_q <= rx_s;
        if (samp_q == SAMP_H)   s1_q <= rx_s;
      end else if (active) begin
        div_q <= div_q + 1'b1;
      end

      case (state_q)
        ARM: begin
          if (rx_s) state_q <= IDLE;
        end
        IDLE: begin
          if (!rx_s) begin
            div_q   <= '0;
            samp_q  <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (decide) begin
            if (maj) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
              bit_q   <= '0;
              dec_q   <= 1'b0;
            end
          end
        end
        DATA: begin
          // The first wrap seen here closes the start bit, so only a wrap that
          // follows a decision advances the bit index.
          if (decide) begin
            shift_q <= {maj, shift_q[PKT_LEN-1:1]};
            dec_q   <= 1'b1;
          end
          if (wrap && dec_q) begin
            dec_q <= 1'b0;
            if (bit_q == BIT_LAST) begin
`ifdef MOVE_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
`ifdef MOVE_RX_PARITY_EN
        PARITY: begin
          if (decide) par_q <= maj;
          if (wrap) state_q <= STOP;
        end
`endif
        STOP: begin
          if (decide) begin
            if (maj && par_ok) begin
              data_q  <= shift_q;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ARM;
            end
          end
        end
        default: state_q <= ARM;
      endcase
    end
  end

endmodule
